// File: rtl/latch_bank_snapshot.sv
// Multi-channel enable-captured storage bank with optional transparent outputs,
// per-channel change tracking and an atomic valid/ready snapshot port.
module latch_bank_snapshot #(
    parameter int                 WIDTH       = 8,
    parameter int                 CHANNELS    = 4,
    parameter bit                 TRANSPARENT = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          en,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic [CHANNELS-1:0]          dirty,
    input  logic                         snap_req,
    output logic                         snap_valid,
    input  logic                         snap_ready,
    output logic [CHANNELS*WIDTH-1:0]    snap_data,
    output logic [CHANNELS-1:0]          snap_dirty,
    output logic                         snap_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                       state_r;
    logic [CHANNELS*WIDTH-1:0]    q_r;
    logic [CHANNELS-1:0]          dirty_r;
    logic                         snap_valid_r;
    logic [CHANNELS*WIDTH-1:0]    snap_data_r;
    logic [CHANNELS-1:0]          snap_dirty_r;
    logic                         snap_drop_r;
    logic [CHANNELS-1:0]          set_s;
    logic                         take_s;
    logic [CHANNELS*WIDTH-1:0]    q_s;

    // Change detection per channel and snapshot acceptance condition.
    always_comb begin
        set_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (en[c] && (d[c*WIDTH +: WIDTH] != q_r[c*WIDTH +: WIDTH])) begin
                set_s[c] = 1'b1;
            end else begin
                set_s[c] = 1'b0;
            end
        end
        take_s = snap_req && (!snap_valid_r || snap_ready);
    end

    // Channel storage: each channel captures its input while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {CHANNELS{RESET_VAL}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (en[c]) begin
                    q_r[c*WIDTH +: WIDTH] <= d[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Dirty tracking; a snapshot keeps only writes landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_r <= {CHANNELS{1'b0}};
        end else if (take_s) begin
            dirty_r <= set_s;
        end else begin
            dirty_r <= dirty_r | set_s;
        end
    end

    // Snapshot handshake FSM with registered valid, payload and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            snap_valid_r <= 1'b0;
            snap_data_r  <= {CHANNELS{RESET_VAL}};
            snap_dirty_r <= {CHANNELS{1'b0}};
            snap_drop_r  <= 1'b0;
        end else begin
            snap_drop_r <= snap_req && snap_valid_r && !snap_ready;
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        state_r      <= HOLD;
                        snap_valid_r <= 1'b1;
                        snap_data_r  <= q_r;
                        snap_dirty_r <= dirty_r;
                    end else begin
                        state_r      <= IDLE;
                        snap_valid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (take_s) begin
                        state_r      <= HOLD;
                        snap_valid_r <= 1'b1;
                        snap_data_r  <= q_r;
                        snap_dirty_r <= dirty_r;
                    end else if (snap_ready) begin
                        state_r      <= IDLE;
                        snap_valid_r <= 1'b0;
                    end else begin
                        state_r      <= HOLD;
                        snap_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    snap_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Output path: flop plus mux gives pass-through without a latch.
    generate
        if (TRANSPARENT) begin : g_transparent
            always_comb begin
                q_s = q_r;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (en[c]) begin
                        q_s[c*WIDTH +: WIDTH] = d[c*WIDTH +: WIDTH];
                    end else begin
                        q_s[c*WIDTH +: WIDTH] = q_r[c*WIDTH +: WIDTH];
                    end
                end
            end
        end else begin : g_registered
            assign q_s = q_r;
        end
    endgenerate

    assign q          = q_s;
    assign dirty      = dirty_r;
    assign snap_valid = snap_valid_r;
    assign snap_data  = snap_data_r;
    assign snap_dirty = snap_dirty_r;
    assign snap_drop  = snap_drop_r;

endmodule

// File: tb/tb_latch_bank_snapshot.sv
// Directed bench for latch_bank_snapshot: a transparent bank (reset 0) and a
// registered bank (reset A5) share stimulus; snapshots are scoreboarded.
module tb_latch_bank_snapshot;

    localparam int W = 8;
    localparam int C = 4;

    typedef struct packed {
        logic [C*W-1:0] data;
        logic [C-1:0]   dirty;
    } snap_t;

    logic           clk;
    logic           rst_n;
    logic [C-1:0]   en;
    logic [C*W-1:0] d;
    logic           snap_req;
    logic           snap_ready;

    logic [C*W-1:0] q,  r_q;
    logic [C-1:0]   dirty, r_dirty;
    logic           snap_valid, r_snap_valid;
    logic [C*W-1:0] snap_data, r_snap_data;
    logic [C-1:0]   snap_dirty, r_snap_dirty;
    logic           snap_drop, r_snap_drop;

    int    n_checks;
    int    n_errors;
    snap_t sb[$];

    latch_bank_snapshot #(.WIDTH(W), .CHANNELS(C), .TRANSPARENT(1'b1), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q), .dirty(dirty),
        .snap_req(snap_req), .snap_valid(snap_valid), .snap_ready(snap_ready),
        .snap_data(snap_data), .snap_dirty(snap_dirty), .snap_drop(snap_drop)
    );

    latch_bank_snapshot #(.WIDTH(W), .CHANNELS(C), .TRANSPARENT(1'b0), .RESET_VAL(8'hA5)) dut_r (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(r_q), .dirty(r_dirty),
        .snap_req(snap_req), .snap_valid(r_snap_valid), .snap_ready(snap_ready),
        .snap_data(r_snap_data), .snap_dirty(r_snap_dirty), .snap_drop(r_snap_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        snap_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {63'd0, snap_valid}, 64'd1);
            chk({tag, "_data"},  {32'd0, snap_data},  {32'd0, e.data});
            chk({tag, "_sdirty"}, {60'd0, snap_dirty}, {60'd0, e.dirty});
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b1;
        en         = 4'b0000;
        d          = 32'h0000_0000;
        snap_req   = 1'b0;
        snap_ready = 1'b0;

        // Asynchronous reset in the middle of a cycle
        #3 rst_n = 1'b0;
        #1;
        chk("rst_r_q",      {32'd0, r_q},          64'hA5A5A5A5);
        chk("rst_r_dirty",  {60'd0, r_dirty},      64'd0);
        chk("rst_r_valid",  {63'd0, r_snap_valid}, 64'd0);
        chk("rst_r_sdata",  {32'd0, r_snap_data},  64'hA5A5A5A5);
        chk("rst_q",        {32'd0, q},            64'd0);
        chk("rst_drop",     {63'd0, snap_drop},    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Transparent vs registered capture of ch1
        en = 4'b0010; d[15:8] = 8'h3C;
        #1;
        chk("tr_q1_same",   {56'd0, q[15:8]},   64'h3C);
        chk("reg_q1_before",{56'd0, r_q[15:8]}, 64'hA5);
        tick();
        chk("reg_q1_after", {56'd0, r_q[15:8]}, 64'h3C);
        en = 4'b0000; d[15:8] = 8'hFF;
        #1;
        chk("tr_q1_hold",   {56'd0, q[15:8]},   64'h3C);
        tick();
        chk("reg_q1_hold",  {56'd0, r_q[15:8]}, 64'h3C);
        chk("dirty_ch1",    {60'd0, dirty},     64'b0010);

        // Dirty set by ch0 write, then cleared by a snapshot
        en = 4'b0001; d[7:0] = 8'h11;
        tick();
        en = 4'b0000;
        chk("dirty_ch0",    {60'd0, dirty},     64'b0011);
        snap_req = 1'b1; snap_ready = 1'b1;
        sb.push_back('{data: 32'h0000_3C11, dirty: 4'b0011});
        tick();
        snap_req = 1'b0;
        sb_check("snap1");
        chk("snap1_dirty_clr", {60'd0, dirty}, 64'd0);
        tick();
        chk("snap1_release", {63'd0, snap_valid}, 64'd0);
        en = 4'b0001; d[7:0] = 8'h11;
        tick();
        en = 4'b0000;
        chk("rewrite_equal", {60'd0, dirty}, 64'd0);

        // Snapshot held while the consumer stalls
        en = 4'b0100; d[23:16] = 8'h77;
        tick();
        en = 4'b0000;
        chk("dirty_ch2", {60'd0, dirty}, 64'b0100);
        snap_ready = 1'b0; snap_req = 1'b1;
        sb.push_back('{data: 32'h0077_3C11, dirty: 4'b0100});
        tick();
        snap_req = 1'b0;
        sb_check("snap2");
        chk("snap2_dirty_clr", {60'd0, dirty}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {63'd0, snap_valid}, 64'd1);
            chk("hold_data",  {32'd0, snap_data},  64'h0077_3C11);
        end

        // Refused request: drop pulse, payload untouched, dirty kept
        snap_req = 1'b1; en = 4'b0001; d[7:0] = 8'h22;
        tick();
        snap_req = 1'b0; en = 4'b0000;
        chk("drop_pulse",  {63'd0, snap_drop},  64'd1);
        chk("drop_data",   {32'd0, snap_data},  64'h0077_3C11);
        chk("drop_sdirty", {60'd0, snap_dirty}, 64'b0100);
        chk("drop_dirty",  {60'd0, dirty},      64'b0001);
        tick();
        chk("drop_end",    {63'd0, snap_drop},  64'd0);
        snap_ready = 1'b1;
        tick();
        chk("snap2_release", {63'd0, snap_valid}, 64'd0);

        // Snapshot concurrent with a ch3 write sees pre-write contents
        en = 4'b1000; d[31:24] = 8'h99; snap_req = 1'b1;
        sb.push_back('{data: 32'h0077_3C22, dirty: 4'b0001});
        tick();
        en = 4'b0000; snap_req = 1'b0;
        sb_check("snap3");
        chk("conc_dirty", {60'd0, dirty}, 64'b1000);
        chk("conc_q",     {32'd0, q},     64'h9977_3C22);
        tick();
        chk("snap3_release", {63'd0, snap_valid}, 64'd0);

        // Back-to-back snapshots with the consumer always ready
        en = 4'b0001; d[7:0] = 8'hA1; snap_req = 1'b1;
        sb.push_back('{data: 32'h9977_3C22, dirty: 4'b1000});
        tick();
        sb_check("b2b_a");
        chk("b2b_a_drop", {63'd0, snap_drop}, 64'd0);
        d[7:0] = 8'hB2;
        sb.push_back('{data: 32'h9977_3CA1, dirty: 4'b0001});
        tick();
        sb_check("b2b_b");
        chk("b2b_b_drop", {63'd0, snap_drop}, 64'd0);
        d[7:0] = 8'hC3;
        sb.push_back('{data: 32'h9977_3CB2, dirty: 4'b0001});
        tick();
        sb_check("b2b_c");
        chk("b2b_c_drop", {63'd0, snap_drop}, 64'd0);
        snap_req = 1'b0; en = 4'b0000;
        tick();
        chk("b2b_release", {63'd0, snap_valid}, 64'd0);
        chk("b2b_dirty",   {60'd0, dirty},      64'b0001);

        // Reset during a stalled handshake discards the pending snapshot
        snap_ready = 1'b0; snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("pre_rst_valid", {63'd0, snap_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, snap_valid}, 64'd0);
        chk("mid_rst_data",  {32'd0, snap_data},  64'd0);
        chk("mid_rst_dirty", {60'd0, dirty},      64'd0);
        chk("mid_rst_r_q",   {32'd0, r_q},        64'hA5A5A5A5);
        chk("sb_drained",    {32'd0, 32'(sb.size())}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
